pwm_deadtime: RTL
=================

// Module: pwm_deadtime
// PURPOSE
//   Downstream stage of the sine PWM generator. Takes its single-ended pwm_out and
//   produces a complementary high-side/low-side gate-drive pair with programmable
//   dead time, so both switches of a half-bridge are never on together.
//   Also provides a latched fault shutdown.
//   Sits between the sine PWM generator and the FPGA output pins. One instance per phase.
// PARAMETERS
//   DT_WIDTH  8  width of the dead_time input and of the internal dead-time down-counter
// PORTS
//   clk         in   1         system clock; all logic on rising edge
//   rst_n       in   1         asynchronous active-low reset
//   enable      in   1         1 = bridge may switch; 0 = both outputs off
//   fault       in   1         synchronous fault request; forces shutdown
//   dead_time   in   DT_WIDTH  dead-time length in clocks (see gap rule)
//   pwm_in      in   1         single-ended PWM from the sine PWM generator
//   pwm_hi      out  1         high-side gate drive, registered
//   pwm_lo      out  1         low-side gate drive, registered
//   in_dead     out  1         1 while in DEAD state
//   fault_lat   out  1         1 while in FAULT state
// BEHAVIOUR
//   Reset: state=IDLE, cnt=0, pwm_q=0; pwm_hi=pwm_lo=in_dead=fault_lat=0.
//   pwm_q: pwm_in delayed by 1 register (2 with the sync option).
//   States (all outputs registered, one-hot decode of state):
//   - IDLE: hi=0, lo=0.
//     - enable=1 & fault=0 -> DEAD, cnt<=dead_time.
//   - DEAD: hi=0, lo=0, in_dead=1.
//     - cnt!=0: cnt<=cnt-1.
//     - cnt==0: -> HI_ON if pwm_q=1, else LO_ON.
//   - HI_ON: hi=1. pwm_q=0 -> DEAD, cnt<=dead_time; hi drops the same edge.
//   - LO_ON: lo=1. pwm_q=1 -> DEAD, cnt<=dead_time; lo drops the same edge.
//   - FAULT: hi=0, lo=0, fault_lat=1.
//     - Exit to IDLE only when fault=0 and enable=0 in the same cycle.
//   Priority (every state): fault=1 -> FAULT > enable=0 -> IDLE > normal transitions.
//   Gap rule: both outputs low for exactly dead_time+1 clocks between one side falling
//     and either side rising. dead_time=0 still gives a 1-clock gap. Overlap is impossible.
//   dead_time is sampled only when cnt is loaded; changing it mid-DEAD has no effect.
//   Pulse swallowing: a pwm_q pulse that starts and ends inside DEAD is ignored.
//     The target side is chosen from pwm_q at the cnt==0 cycle only.
//     A pulse shorter than dead_time+1 clocks therefore never reaches a gate.
//   Start-up: leaving IDLE always passes through a full DEAD period.
//   Latency, no sync: pwm_in edge -> falling gate output after 2 clocks;
//     opposite gate rises dead_time+1 clocks later.
//   Async reset mid-operation: outputs go to 0 immediately, without waiting for clk.
// CONFIGURATION
//   PWM_DT_SYNC_EN defined:
//     pwm_in passes through a 2-flop synchroniser before pwm_q (pwm_q = pwm_in delayed 2).
//     All edge latencies grow by 1 clock. Use when pwm_in is asynchronous to clk.
//   PWM_DT_SYNC_EN undefined:
//     single register; pwm_in must be synchronous to clk.
// TESTING (no sync unless stated; dead_time=4)
//   1. Reset, enable=1, pwm_in=1 held -> hi,lo=0 for 5 clocks in DEAD (in_dead=1), then hi=1.
//   2. In HI_ON, pwm_in 1->0 -> hi=0 2 clocks later; lo=1 exactly 5 clocks after hi fell;
//      never hi&lo.
//   3. pwm_in 2-clock high pulse during LO_ON -> lo off 5 clocks,
//      then lo=1 again, hi stays 0 throughout.
//   4. fault=1 in HI_ON -> next clock hi=0, fault_lat=1;
//      drop fault with enable=1 -> stays FAULT; enable=0 -> IDLE, fault_lat=0.
//   5. dead_time=0, pwm_in toggling every 8 clocks -> exactly 1-clock gap on every transition.
//   6. PWM_DT_SYNC_EN defined, repeat test 2 -> hi falls 3 clocks after pwm_in; gap unchanged at 5.

Source files
------------

// File: rtl/pwm_deadtime.sv
// Complementary gate-drive generator with programmable dead time and latched
// fault shutdown. Turns a single-ended PWM into a high-side/low-side pair that
// can never be on at the same time.
// Optional macro PWM_DT_SYNC_EN: adds a 2-flop synchroniser on pwm_in for use
// when pwm_in is asynchronous to clk. All edge latencies then grow by 1 clock.
module pwm_deadtime #(
   parameter int unsigned DT_WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                fault,
   input  logic [DT_WIDTH-1:0] dead_time,
   input  logic                pwm_in,
   output logic                pwm_hi,
   output logic                pwm_lo,
   output logic                in_dead,
   output logic                fault_lat
);

   // One-hot encoding. Each output is a registered decode of the next state.
   typedef enum logic [4:0] {
      IDLE  = 5'b00001,
      DEAD  = 5'b00010,
      HI_ON = 5'b00100,
      LO_ON = 5'b01000,
      FAULT = 5'b10000
   } state_t;

   state_t              state, state_nxt;
   logic [DT_WIDTH-1:0] cnt, cnt_nxt;
   logic                pwm_q;

`ifdef PWM_DT_SYNC_EN
   logic pwm_s1;

   // Two-flop synchroniser for an asynchronous pwm_in
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_s1 <= 1'b0;
         pwm_q  <= 1'b0;
      end else begin
         pwm_s1 <= pwm_in;
         pwm_q  <= pwm_s1;
      end
   end
`else
   // Single input register for a pwm_in already synchronous to clk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_q <= 1'b0;
      end else begin
         pwm_q <= pwm_in;
      end
   end
`endif

   // State, dead-time counter and registered output decode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         pwm_hi    <= 1'b0;
         pwm_lo    <= 1'b0;
         in_dead   <= 1'b0;
         fault_lat <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         pwm_hi    <= (state_nxt == HI_ON);
         pwm_lo    <= (state_nxt == LO_ON);
         in_dead   <= (state_nxt == DEAD);
         fault_lat <= (state_nxt == FAULT);
      end
   end

   // Next state: fault beats disable, disable beats normal switching.
   // The counter is loaded only on entry to DEAD, so dead_time is sampled there only.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (fault) begin
         state_nxt = FAULT;
      end else if (!enable) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               state_nxt = DEAD;
               cnt_nxt   = dead_time;
            end
            DEAD: begin
               // Side is chosen from pwm_q only when the gap expires
               if (cnt != '0) begin
                  cnt_nxt = cnt - DT_WIDTH'(1);
               end else begin
                  state_nxt = pwm_q ? HI_ON : LO_ON;
               end
            end
            HI_ON: begin
               if (!pwm_q) begin
                  state_nxt = DEAD;
                  cnt_nxt   = dead_time;
               end
            end
            LO_ON: begin
               if (pwm_q) begin
                  state_nxt = DEAD;
                  cnt_nxt   = dead_time;
               end
            end
            FAULT: begin
               // Latched until fault and enable are both low together
               state_nxt = FAULT;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

endmodule
